// File: rtl/ones_density_ctrl_pkg.sv
// ones_ctrl_pkg: FSM state encoding and count-width helper shared by the ones density controller.
package ones_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_e;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/ones_density_ctrl_if.sv
// ones_density_ctrl_if: input-word and result handshakes plus busy status of the ones density controller.
interface ones_density_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = ones_ctrl_pkg::cnt_w(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_over;
  logic             busy;
  modport master (
    output in_valid, in_data, thresh, out_ready,
    input  in_ready, out_valid, out_count, out_over, busy
  );
  modport slave (
    input  in_valid, in_data, thresh, out_ready,
    output in_ready, out_valid, out_count, out_over, busy
  );
endinterface

// File: rtl/ones_density_ctrl_shift_count.sv
// ones_shift_count: LSB-first shift register, remaining-bit counter and ones accumulator.
module ones_shift_count import ones_ctrl_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             last
);
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bits_q, bits_d, cnt_q, cnt_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end
  always_comb begin
    sr_d   = load ? data : shift ? sr_q >> 1 : sr_q;
    bits_d = load ? CNT_W'(WIDTH) : shift ? bits_q - CNT_W'(1) : bits_q;
    cnt_d  = load ? '0 : shift ? cnt_q + CNT_W'(sr_q[0]) : cnt_q;
  end
  assign count = cnt_q;
  assign last  = bits_q == CNT_W'(1);
endmodule

// File: rtl/ones_density_ctrl.sv
// ones_density_ctrl: counts ones of an accepted word serially and reports count and threshold compare.
// Defining ONES_CTRL_ABORT_EN adds an abort input that drops any in-flight word.
module ones_density_ctrl import ones_ctrl_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input logic clk,
  input logic reset,
`ifdef ONES_CTRL_ABORT_EN
  input logic abort,
`endif
  ones_density_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] thresh_q, thresh_d, count;
  logic             accept, last, kill;
`ifdef ONES_CTRL_ABORT_EN
  assign kill = abort && state_q != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign accept = state_q == IDLE && bus.in_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      thresh_q <= '0;
    end else begin
      state_q  <= state_d;
      thresh_q <= thresh_d;
    end
  end
  always_comb begin
    thresh_d = accept ? bus.thresh : thresh_q;
    state_d  = kill ? IDLE :
               state_q == IDLE  ? (bus.in_valid ? SHIFT : IDLE) :
               state_q == SHIFT ? (last ? REPORT : SHIFT) :
               bus.out_ready    ? IDLE : REPORT;
  end
  // Result outputs are forced to zero whenever no result is being reported.
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.busy      = state_q != IDLE;
    bus.out_valid = state_q == REPORT;
    bus.out_count = state_q == REPORT ? count : '0;
    bus.out_over  = state_q == REPORT && count >= thresh_q;
  end
  ones_shift_count #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shift_count (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state_q == SHIFT),
    .data  (bus.in_data),
    .count (count),
    .last  (last)
  );
endmodule
